macc_psum_requant: RTL and testbench
====================================

// Module: macc_psum_requant
// PURPOSE
//  Consumer end of the 1-to-n 8-bit MACC array. Accumulates NUM_CHUNKS
//  partial-sum beats per output group, adds a per-lane bias, then
//  rounds, shifts, optionally applies ReLU and saturates each lane to int8.
//  The 8-bit result feeds the next conv stage.
// PARAMETERS
//  NUM_INPUTS  9   products per MACC lane upstream; sets IN_W = 16 + $clog2(NUM_INPUTS)
//  NUM_MACC    5   parallel lanes
//  NUM_CHUNKS  4   beats accumulated per output (>=1)
//  ACC_W       32  accumulator width; must be >= IN_W + $clog2(NUM_CHUNKS) + 1
//  RELU        0   1: clamp negative results to 0 before saturation
// PORTS
//  clk      in   1              clock, rising edge
//  rst      in   1              asynchronous reset, active-high
//  i_data   in   IN_W*NUM_MACC  signed partial sums, lane k at [(k+1)*IN_W-1:k*IN_W]
//  i_valid  in   1              i_data beat valid; no backpressure
//  i_bias   in   16*NUM_MACC    signed per-lane bias, sampled on the first beat of a group
//  i_shift  in   5              right-shift amount 0..31, sampled on the first beat
//  i_clear  in   1              synchronous abort of the current group
//  o_data   out  8*NUM_MACC     signed int8 results, lane k at [(k+1)*8-1:k*8]
//  o_valid  out  1              one-cycle pulse per completed group
//  o_busy   out  1              high while a group is partially accumulated
// BEHAVIOUR
//  Reset: cnt=0, acc=0, o_data=0, o_valid=0, o_busy=0. Reset mid-group discards the group.
//  Beat counter cnt runs 0..NUM_CHUNKS-1; it advances only on i_valid. Gaps between beats are allowed.
//  On i_valid with cnt==0:
//   - acc[k] <= sext(bias[k]) + sext(i_data[k]).
//   - Latch i_shift.
//  On i_valid with cnt>0: acc[k] <= acc[k] + sext(i_data[k]).
//  Last beat (cnt==NUM_CHUNKS-1):
//   - cnt wraps to 0.
//   - done flag set for one cycle.
//  Requant stage, registered on the done cycle, all lanes identical:
//   - r = acc + (sh ? 1<<(sh-1) : 0), computed at ACC_W+1 bits with no wrap.
//   - q = r >>> sh (arithmetic shift).
//   - If RELU and q<0, q=0.
//   - o_data lane = sat(q, -128, 127).
//  Latency: o_valid is high exactly 2 cycles after the edge sampling the last beat.
//   - o_data then holds until the next group completes.
//  NUM_CHUNKS==1: every i_valid is a complete group. Back-to-back groups give back-to-back o_valid.
//  i_clear:
//   - Forces cnt=0.
//   - Kills a pending done, so no o_valid follows.
//   - If i_valid arrives in the same cycle, that beat is taken as cnt==0 of a new group.
//   - o_data is untouched.
//  o_busy = (cnt != 0).
//  Accumulator overflow is impossible by the ACC_W rule. A simulation assertion checks the rule at elaboration.
// STRUCTURE
//  Shared package: IN_W function, INT8_MIN/INT8_MAX constants, width-rule check function.
//  Sub-module requant_sat_8bit, one instance per lane:
//   - Combinational round/shift/ReLU/saturate, ACC_W in, 8 out.
//   - The top owns the counter, accumulators and output registers.
// TESTING  (defaults, IN_W=20)
//  1. 4 beats with lane0=100, bias=0, shift=2 -> lane0=100; o_valid 2 cycles after 4th beat.
//  2. Rounding, shift=2: acc=6 -> 2; acc=-6 -> -1; acc=5 -> 1; shift=0 on acc=7 -> 7.
//  3. Saturation, shift=4: acc=100000 -> 127; acc=-100000 -> -128; RELU=1 build gives 0 for the negative case.
//  4. Bias: lane3 bias=-300, all data 0, shift=0 -> -128; bias=50 -> 50. Bias changes on beats 1-3 are ignored.
//  5. i_clear after 2 beats, then 4 beats of 1 (bias 0, shift 0) -> single o_valid with 4.
//     Repeat with i_clear coincident with the first new beat -> same result.
//  6. rst asserted after 3 beats -> o_valid=0, o_data=0, o_busy=0; next 4 beats form a fresh group.
//     Random gaps in i_valid versus a reference model must give identical results.

Source files
------------

// File: rtl/macc_psum_requant_pkg.sv
// Shared constants and elaboration helpers for the partial-sum requantiser.
package macc_psum_requant_pkg;

    localparam int INT8_MIN = -128;
    localparam int INT8_MAX = 127;
    localparam int SHIFT_W  = 5;

    // Width of one upstream MACC lane: a 16-bit product grown by the adder tree.
    function automatic int calc_in_w(input int num_inputs);
        return 16 + $clog2(num_inputs);
    endfunction

    // The accumulator must hold NUM_CHUNKS lane sums plus the bias without wrapping.
    function automatic bit acc_w_ok(input int acc_w, input int in_w, input int num_chunks);
        return acc_w >= in_w + $clog2(num_chunks) + 1;
    endfunction

endpackage

// File: rtl/requant_sat_8bit.sv
// Per-lane requantiser: round half up, arithmetic shift, optional ReLU,
// saturate to int8. Purely combinational.
module requant_sat_8bit
    import macc_psum_requant_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter bit RELU  = 1'b0
) (
    input  logic signed [ACC_W-1:0]   acc,
    input  logic        [SHIFT_W-1:0] shift,
    output logic signed [7:0]         q
);

    localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'(INT8_MAX);
    localparam logic signed [ACC_W:0] Q_MIN = (ACC_W+1)'(INT8_MIN);

    // Rounding is done one bit wider than the accumulator so adding the
    // half-LSB can never wrap a large positive value negative.
    function automatic logic signed [ACC_W:0] round_shift(
        input logic signed [ACC_W-1:0]   a,
        input logic        [SHIFT_W-1:0] sh
    );
        logic signed [ACC_W:0] r;
        r = {a[ACC_W-1], a};
        if (sh != '0) begin
            r = r + $signed((ACC_W+1)'(1) << (sh - SHIFT_W'(1)));
        end
        return r >>> sh;
    endfunction

    // Optional ReLU followed by clamping into the int8 range.
    function automatic logic signed [7:0] relu_sat8(input logic signed [ACC_W:0] v);
        logic signed [ACC_W:0] t;
        t = v;
        if (RELU && (t < 0)) begin
            t = '0;
        end
        if (t > Q_MAX) begin
            t = Q_MAX;
        end else if (t < Q_MIN) begin
            t = Q_MIN;
        end
        return t[7:0];
    endfunction

    // Round/shift then clamp the lane result.
    always_comb begin
        q = relu_sat8(round_shift(acc, shift));
    end

endmodule

// File: rtl/macc_psum_requant.sv
// Consumer end of the 8-bit MACC array: accumulates NUM_CHUNKS partial-sum
// beats per output group, adds a per-lane bias and requantises each lane
// to int8. o_valid pulses two cycles after the edge taking the last beat.
module macc_psum_requant
    import macc_psum_requant_pkg::*;
#(
    parameter int  NUM_INPUTS = 9,
    parameter int  NUM_MACC   = 5,
    parameter int  NUM_CHUNKS = 4,
    parameter int  ACC_W      = 32,
    parameter bit  RELU       = 1'b0,
    localparam int IN_W       = calc_in_w(NUM_INPUTS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_W*NUM_MACC-1:0] i_data,
    input  logic                     i_valid,
    input  logic [16*NUM_MACC-1:0]   i_bias,
    input  logic [SHIFT_W-1:0]       i_shift,
    input  logic                     i_clear,
    output logic [8*NUM_MACC-1:0]    o_data,
    output logic                     o_valid,
    output logic                     o_busy
);

    localparam int               CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_CHUNKS - 1);

    if (NUM_CHUNKS < 1) begin : g_chunks_check
        $error("macc_psum_requant: NUM_CHUNKS=%0d must be at least 1", NUM_CHUNKS);
    end
    if (!acc_w_ok(ACC_W, IN_W, NUM_CHUNKS)) begin : g_acc_w_check
        $error("macc_psum_requant: ACC_W=%0d too narrow for IN_W=%0d, NUM_CHUNKS=%0d",
               ACC_W, IN_W, NUM_CHUNKS);
    end

    logic        [CNT_W-1:0]   cnt;
    logic        [CNT_W-1:0]   cnt_eff;
    logic                      first_beat;
    logic                      last_beat;
    logic                      out_en;
    logic signed [ACC_W-1:0]   data_ext [NUM_MACC];
    logic signed [ACC_W-1:0]   bias_ext [NUM_MACC];
    logic signed [ACC_W-1:0]   acc_p0   [NUM_MACC];
    logic        [SHIFT_W-1:0] sh_p0;
    logic                      vld_p0;
    logic signed [7:0]         q_lane   [NUM_MACC];

    // A clear in the same cycle as a beat restarts the group at that beat.
    assign cnt_eff    = i_clear ? '0 : cnt;
    assign first_beat = (cnt_eff == '0);
    assign last_beat  = (cnt_eff == LAST);
    assign out_en     = vld_p0 && !i_clear;
    assign o_busy     = (cnt != '0);

    for (genvar k = 0; k < NUM_MACC; k++) begin : g_lane
        assign data_ext[k] = {{(ACC_W-IN_W){i_data[k*IN_W+IN_W-1]}}, i_data[k*IN_W +: IN_W]};
        assign bias_ext[k] = {{(ACC_W-16){i_bias[k*16+15]}}, i_bias[k*16 +: 16]};

        requant_sat_8bit #(
            .ACC_W (ACC_W),
            .RELU  (RELU)
        ) u_requant (
            .acc   (acc_p0[k]),
            .shift (sh_p0),
            .q     (q_lane[k])
        );
    end

    // Beat counter: advances on each accepted beat, wraps after the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (i_valid) begin
            cnt <= last_beat ? '0 : cnt_eff + CNT_W'(1);
        end else if (i_clear) begin
            cnt <= '0;
        end
    end

    // Stage p0: bias-seeded accumulation; shift is captured on the first beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_p0 <= '0;
            for (int k = 0; k < NUM_MACC; k++) begin
                acc_p0[k] <= '0;
            end
        end else if (i_valid) begin
            if (first_beat) begin
                sh_p0 <= i_shift;
            end
            for (int k = 0; k < NUM_MACC; k++) begin
                acc_p0[k] <= first_beat ? bias_ext[k] + data_ext[k]
                                        : acc_p0[k] + data_ext[k];
            end
        end
    end

    // Done flag: one cycle after the edge that took the last beat of a group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= i_valid && last_beat;
        end
    end

    // Stage p1: register requantised lanes; a clear in the done cycle suppresses them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= out_en;
            if (out_en) begin
                for (int k = 0; k < NUM_MACC; k++) begin
                    o_data[k*8 +: 8] <= q_lane[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_macc_psum_requant.sv
// Scoreboard bench for macc_psum_requant at default parameters (IN_W=20),
// with a RELU=1 twin instance sharing the same stimulus.
module tb_macc_psum_requant;

    localparam int IN_W = 20;
    localparam int NM   = 5;

    logic              clk;
    logic              rst;
    logic [IN_W*NM-1:0] i_data;
    logic              i_valid;
    logic [16*NM-1:0]  i_bias;
    logic [4:0]        i_shift;
    logic              i_clear;
    logic [8*NM-1:0]   o_data;
    logic              o_valid;
    logic              o_busy;
    logic [8*NM-1:0]   o_data_r;
    logic              o_valid_r;
    logic              o_busy_r;

    macc_psum_requant #(.RELU(1'b0)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_bias(i_bias),
        .i_shift(i_shift), .i_clear(i_clear), .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy)
    );

    macc_psum_requant #(.RELU(1'b1)) dut_r (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_bias(i_bias),
        .i_shift(i_shift), .i_clear(i_clear), .o_data(o_data_r), .o_valid(o_valid_r), .o_busy(o_busy_r)
    );

    typedef struct {
        logic [8*NM-1:0] d;
        logic [8*NM-1:0] dr;
        longint          cyc;
        string           nm;
    } exp_t;

    exp_t   sbq[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;
    longint last_cyc = 0;
    int     bd[NM];
    int     bb[NM];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8*NM-1:0] p8(input int a, input int b, input int c, input int d, input int e);
        return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Reference requantiser: floor((acc + half) / 2^sh), ReLU, clamp.
    function automatic logic [7:0] ref_q(input longint acc, input int sh, input bit relu);
        longint r, d, q;
        d = longint'(1) << sh;
        r = acc + ((sh > 0) ? d / 2 : 0);
        if (r >= 0) q = r / d;
        else        q = -((-r + d - 1) / d);
        if (relu && q < 0) q = 0;
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q[7:0];
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic drive_beat(input logic [4:0] sh, input logic clr);
        @(negedge clk);
        for (int k = 0; k < NM; k++) begin
            i_data[k*IN_W +: IN_W] = IN_W'(bd[k]);
            i_bias[k*16 +: 16]     = 16'(bb[k]);
        end
        i_shift  = sh;
        i_valid  = 1'b1;
        i_clear  = clr;
        last_cyc = cyc;
    endtask

    task automatic drive_idle(input logic clr);
        @(negedge clk);
        i_valid = 1'b0;
        i_clear = clr;
    endtask

    task automatic push_exp(input logic [8*NM-1:0] d, input logic [8*NM-1:0] dr, input string nm);
        exp_t e;
        e.d   = d;
        e.dr  = dr;
        e.cyc = last_cyc + 2;
        e.nm  = nm;
        sbq.push_back(e);
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < NM; k++) bd[k] = v;
    endtask

    // Monitor: every o_valid pops one expectation and checks data, ReLU twin and latency.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && o_valid) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: o_valid=1 o_data=%h, required no output", o_data);
            end else begin
                e = sbq.pop_front();
                check({e.nm, "_data"}, 64'(o_data), 64'(e.d));
                check({e.nm, "_relu"}, 64'({o_valid_r, o_data_r}), 64'({1'b1, e.dr}));
                check({e.nm, "_latency"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin : stim
        longint acc[NM];
        int     sh;
        int     wait_cnt;
        logic [8*NM-1:0] ed, edr;

        rst = 1'b1; i_valid = 1'b0; i_clear = 1'b0; i_data = '0; i_bias = '0; i_shift = '0;
        set_all(0);
        for (int k = 0; k < NM; k++) bb[k] = 0;
        repeat (3) @(negedge clk);
        check("reset_o_data", 64'(o_data), 64'(0));
        check("reset_o_valid", 64'(o_valid), 64'(0));
        check("reset_o_busy", 64'(o_busy), 64'(0));
        rst = 1'b0;
        drive_idle(0);

        // 1: basic group, shift 2
        bd = '{100, -3, 0, 0, 7};
        repeat (4) drive_beat(5'd2, 0);
        push_exp(p8(100, -3, 0, 0, 7), p8(100, 0, 0, 0, 7), "basic");
        drive_idle(0);
        repeat (3) drive_idle(0);

        // 2: rounding at shift 2, later beats carry a different shift that must be ignored
        bd = '{6, -6, 5, 2, -2};
        drive_beat(5'd2, 0);
        set_all(0);
        repeat (3) drive_beat(5'd9, 0);
        push_exp(p8(2, -1, 1, 1, 0), p8(2, 0, 1, 1, 0), "round_sh2");
        bd = '{7, -7, 0, 0, 0};
        drive_beat(5'd0, 0);
        set_all(0);
        repeat (3) drive_beat(5'd3, 0);
        push_exp(p8(7, -7, 0, 0, 0), p8(7, 0, 0, 0, 0), "round_sh0");
        repeat (3) drive_idle(0);

        // 3: saturation at shift 4, including the exact int8 edges
        bd = '{25000, -25000, 508, 512, -512};
        repeat (4) drive_beat(5'd4, 0);
        push_exp(p8(127, -128, 127, 127, -128), p8(127, 0, 127, 127, 0), "saturate");
        repeat (3) drive_idle(0);

        // 4: bias taken on the first beat only
        set_all(0);
        bb = '{50, 50, 50, -300, 50};
        drive_beat(5'd0, 0);
        bb = '{1000, -1000, 1000, 1000, 1000};
        repeat (3) drive_beat(5'd7, 0);
        push_exp(p8(50, 50, 50, -128, 50), p8(50, 50, 50, 0, 50), "bias_neg");
        bb = '{0, 0, 0, 50, 0};
        drive_beat(5'd0, 0);
        bb = '{0, 0, 0, 0, 0};
        repeat (3) drive_beat(5'd0, 0);
        push_exp(p8(0, 0, 0, 50, 0), p8(0, 0, 0, 50, 0), "bias_pos");
        repeat (3) drive_idle(0);

        // 5a: standalone clear after two beats
        set_all(9);
        repeat (2) drive_beat(5'd0, 0);
        drive_idle(1);
        check("busy_mid_group", 64'(o_busy), 64'(1));
        drive_idle(0);
        check("busy_after_clear", 64'(o_busy), 64'(0));
        set_all(1);
        repeat (4) drive_beat(5'd0, 0);
        push_exp(p8(4, 4, 4, 4, 4), p8(4, 4, 4, 4, 4), "clear_alone");
        repeat (3) drive_idle(0);

        // 5b: clear coincident with the first beat of the new group
        set_all(9);
        repeat (2) drive_beat(5'd0, 0);
        set_all(1);
        drive_beat(5'd0, 1);
        repeat (3) drive_beat(5'd0, 0);
        push_exp(p8(4, 4, 4, 4, 4), p8(4, 4, 4, 4, 4), "clear_with_beat");
        repeat (3) drive_idle(0);

        // 5c: clear in the done cycle kills the output and leaves o_data alone
        set_all(5);
        repeat (4) drive_beat(5'd0, 0);
        drive_idle(1);
        repeat (3) drive_idle(0);
        check("clear_kills_done_data", 64'(o_data), 64'(p8(4, 4, 4, 4, 4)));

        // 6: reset mid-group discards it
        set_all(3);
        repeat (3) drive_beat(5'd0, 0);
        @(negedge clk);
        i_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midreset_o_valid", 64'(o_valid), 64'(0));
        check("midreset_o_data", 64'(o_data), 64'(0));
        check("midreset_o_busy", 64'(o_busy), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        set_all(2);
        repeat (4) drive_beat(5'd0, 0);
        push_exp(p8(8, 8, 8, 8, 8), p8(8, 8, 8, 8, 8), "after_reset");
        repeat (3) drive_idle(0);

        // 6b: random gaps and back-to-back groups against the reference model
        for (int g = 0; g < 8; g++) begin
            sh = $urandom_range(0, 12);
            for (int k = 0; k < NM; k++) begin
                bb[k]  = int'($urandom_range(0, 4000)) - 2000;
                acc[k] = bb[k];
            end
            for (int b = 0; b < 4; b++) begin
                for (int k = 0; k < NM; k++) begin
                    bd[k]  = int'($urandom_range(0, 20000)) - 10000;
                    acc[k] += bd[k];
                end
                drive_beat((b == 0) ? 5'(sh) : 5'($urandom_range(0, 31)), 0);
                if (b < 3 && (g % 2) == 1) repeat ($urandom_range(0, 2)) drive_idle(0);
            end
            for (int k = 0; k < NM; k++) begin
                ed[k*8 +: 8]  = ref_q(acc[k], sh, 1'b0);
                edr[k*8 +: 8] = ref_q(acc[k], sh, 1'b1);
            end
            push_exp(ed, edr, $sformatf("rand%0d", g));
        end
        drive_idle(0);

        wait_cnt = 0;
        while (sbq.size() != 0 && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("scoreboard_drained", 64'(sbq.size()), 64'(0));
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
